// File: rtl/sccb_config_sequencer_if.sv
// SCCB transaction handshake between the configuration sequencer (master)
// and the bit-level SCCB engine (slave). One request is outstanding at a time;
// the slave answers with a single-cycle xfer_ack, qualified by xfer_nack/xfer_rdata.
interface sccb_config_sequencer_if;
  logic       xfer_req;
  logic       xfer_rd;
  logic [7:0] xfer_addr;
  logic [7:0] xfer_wdata;
  logic       xfer_ack;
  logic       xfer_nack;
  logic [7:0] xfer_rdata;

  modport master (
    output xfer_req, xfer_rd, xfer_addr, xfer_wdata,
    input  xfer_ack, xfer_nack, xfer_rdata
  );

  modport slave (
    input  xfer_req, xfer_rd, xfer_addr, xfer_wdata,
    output xfer_ack, xfer_nack, xfer_rdata
  );
endinterface

// File: rtl/sccb_config_sequencer.sv
// SCCB configuration sequencer: walks a combinational {addr, data} LUT,
// performs leading ID-check reads, then writes every remaining entry through
// the SCCB master. Handles power-up settle, soft-reset settle (reg 0x12 bit7),
// NACK retries and sticky pass status.
// Optional build macro SCCB_CFG_VERIFY_EN: read back each ordinary write and
// re-issue it on mismatch; adds the verify_fail output.
module sccb_config_sequencer #(
  parameter int LUT_SIZE       = 173,
  parameter int READ_ENTRIES   = 2,
  parameter int INDEX_W        = 8,
  parameter int POWERUP_CYCLES = 25000,
  parameter int SRST_CYCLES    = 25000,
  parameter int MAX_RETRY      = 3,
  parameter int ID_STRICT      = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [INDEX_W-1:0]     lut_index,
  input  logic [15:0]            lut_data,
  sccb_config_sequencer_if.master sccb,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   id_mismatch,
  output logic [INDEX_W-1:0]     err_index
`ifdef SCCB_CFG_VERIFY_EN
  ,
  output logic                   verify_fail
`endif
);

  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int CNT_MAX = (POWERUP_CYCLES > SRST_CYCLES) ? POWERUP_CYCLES : SRST_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
  localparam logic [CNT_W-1:0]   PWR_LAST    = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SRST_LAST   = CNT_W'(SRST_CYCLES - 1);
  localparam logic [INDEX_W-1:0] LAST_INDEX  = INDEX_W'(LUT_SIZE - 1);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    PWRUP  = 4'd1,
    FETCH  = 4'd2,
    ISSUE  = 4'd3,
    WAIT   = 4'd4,
    CHECK  = 4'd5,
    DELAY  = 4'd6,
    DONE   = 4'd7,
    FAIL   = 4'd8
`ifdef SCCB_CFG_VERIFY_EN
    ,
    VREAD  = 4'd9,
    VCHECK = 4'd10
`endif
  } state_t;

  // A write of 0x12 with bit7 set is the sensor soft reset and needs settle time.
  function automatic logic is_soft_reset(input logic [7:0] addr, input logic [7:0] data);
    return (addr == 8'h12) && data[7];
  endfunction

  state_t               state_r, state_nxt_s;
  logic [INDEX_W-1:0]   lut_index_r, lut_index_nxt_s;
  logic [7:0]           addr_r, addr_nxt_s;
  logic [7:0]           data_r, data_nxt_s;
  logic                 rd_r, rd_nxt_s;
  logic                 req_r, req_nxt_s;
  logic                 nack_r, nack_nxt_s;
  logic [7:0]           rdata_r, rdata_nxt_s;
  logic [RETRY_W-1:0]   retry_r, retry_nxt_s;
  logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
  logic                 busy_r, busy_nxt_s;
  logic                 done_r, done_nxt_s;
  logic                 error_r, error_nxt_s;
  logic                 id_mismatch_r, id_mismatch_nxt_s;
  logic [INDEX_W-1:0]   err_index_r, err_index_nxt_s;
`ifdef SCCB_CFG_VERIFY_EN
  logic                 verify_fail_r, verify_fail_nxt_s;
`endif
  logic                 op_is_read_s;
  logic                 adv_s;
  logic                 fail_s;

  assign op_is_read_s = (32'(lut_index_r) < READ_ENTRIES);

  // State and datapath registers; async reset drops xfer_req immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      lut_index_r   <= '0;
      addr_r        <= 8'h00;
      data_r        <= 8'h00;
      rd_r          <= 1'b0;
      req_r         <= 1'b0;
      nack_r        <= 1'b0;
      rdata_r       <= 8'h00;
      retry_r       <= '0;
      cnt_r         <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      error_r       <= 1'b0;
      id_mismatch_r <= 1'b0;
      err_index_r   <= '0;
`ifdef SCCB_CFG_VERIFY_EN
      verify_fail_r <= 1'b0;
`endif
    end else begin
      state_r       <= state_nxt_s;
      lut_index_r   <= lut_index_nxt_s;
      addr_r        <= addr_nxt_s;
      data_r        <= data_nxt_s;
      rd_r          <= rd_nxt_s;
      req_r         <= req_nxt_s;
      nack_r        <= nack_nxt_s;
      rdata_r       <= rdata_nxt_s;
      retry_r       <= retry_nxt_s;
      cnt_r         <= cnt_nxt_s;
      busy_r        <= busy_nxt_s;
      done_r        <= done_nxt_s;
      error_r       <= error_nxt_s;
      id_mismatch_r <= id_mismatch_nxt_s;
      err_index_r   <= err_index_nxt_s;
`ifdef SCCB_CFG_VERIFY_EN
      verify_fail_r <= verify_fail_nxt_s;
`endif
    end
  end

  // Next-state and next-register logic; entry advance / abort resolved at the end.
  always_comb begin
    state_nxt_s       = state_r;
    lut_index_nxt_s   = lut_index_r;
    addr_nxt_s        = addr_r;
    data_nxt_s        = data_r;
    rd_nxt_s          = rd_r;
    req_nxt_s         = req_r;
    nack_nxt_s        = nack_r;
    rdata_nxt_s       = rdata_r;
    retry_nxt_s       = retry_r;
    cnt_nxt_s         = cnt_r;
    busy_nxt_s        = busy_r;
    done_nxt_s        = done_r;
    error_nxt_s       = error_r;
    id_mismatch_nxt_s = id_mismatch_r;
    err_index_nxt_s   = err_index_r;
`ifdef SCCB_CFG_VERIFY_EN
    verify_fail_nxt_s = verify_fail_r;
`endif
    adv_s  = 1'b0;
    fail_s = 1'b0;

    case (state_r)
      IDLE, DONE, FAIL: begin
        if (start) begin
          done_nxt_s        = 1'b0;
          error_nxt_s       = 1'b0;
          id_mismatch_nxt_s = 1'b0;
`ifdef SCCB_CFG_VERIFY_EN
          verify_fail_nxt_s = 1'b0;
`endif
          lut_index_nxt_s   = '0;
          retry_nxt_s       = '0;
          cnt_nxt_s         = '0;
          busy_nxt_s        = 1'b1;
          state_nxt_s       = (POWERUP_CYCLES == 0) ? FETCH : PWRUP;
        end else begin
          state_nxt_s = state_r;
        end
      end
      PWRUP: begin
        if (cnt_r == PWR_LAST) begin
          cnt_nxt_s   = '0;
          state_nxt_s = FETCH;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      FETCH: begin
        addr_nxt_s  = lut_data[15:8];
        data_nxt_s  = lut_data[7:0];
        rd_nxt_s    = op_is_read_s;
        req_nxt_s   = 1'b1;
        state_nxt_s = ISSUE;
      end
      ISSUE: begin
        state_nxt_s = WAIT;
      end
      WAIT: begin
        if (sccb.xfer_ack) begin
          nack_nxt_s  = sccb.xfer_nack;
          rdata_nxt_s = sccb.xfer_rdata;
          req_nxt_s   = 1'b0;
          state_nxt_s = CHECK;
        end else begin
          req_nxt_s = 1'b1;
        end
      end
      CHECK: begin
        if (nack_r) begin
          if (retry_r < RETRY_LIMIT) begin
            retry_nxt_s = retry_r + RETRY_W'(1);
            req_nxt_s   = 1'b1;
            state_nxt_s = ISSUE;
          end else begin
            fail_s = 1'b1;
          end
        end else if (op_is_read_s) begin
          if (rdata_r != data_r) begin
            id_mismatch_nxt_s = 1'b1;
            if (ID_STRICT != 0) begin
              fail_s = 1'b1;
            end else begin
              adv_s = 1'b1;
            end
          end else begin
            adv_s = 1'b1;
          end
        end else if (is_soft_reset(addr_r, data_r)) begin
          if (SRST_CYCLES == 0) begin
            adv_s = 1'b1;
          end else begin
            cnt_nxt_s   = '0;
            state_nxt_s = DELAY;
          end
        end else begin
`ifdef SCCB_CFG_VERIFY_EN
          rd_nxt_s    = 1'b1;
          req_nxt_s   = 1'b1;
          state_nxt_s = VREAD;
`else
          adv_s = 1'b1;
`endif
        end
      end
      DELAY: begin
        if (cnt_r == SRST_LAST) begin
          cnt_nxt_s = '0;
          adv_s     = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
`ifdef SCCB_CFG_VERIFY_EN
      VREAD: begin
        if (sccb.xfer_ack) begin
          nack_nxt_s  = sccb.xfer_nack;
          rdata_nxt_s = sccb.xfer_rdata;
          req_nxt_s   = 1'b0;
          state_nxt_s = VCHECK;
        end else begin
          req_nxt_s = 1'b1;
        end
      end
      VCHECK: begin
        if (nack_r || (rdata_r != data_r)) begin
          // A NACKed readback is retried but is not a data mismatch.
          verify_fail_nxt_s = verify_fail_r | ~nack_r;
          if (retry_r < RETRY_LIMIT) begin
            retry_nxt_s = retry_r + RETRY_W'(1);
            rd_nxt_s    = 1'b0;
            req_nxt_s   = 1'b1;
            state_nxt_s = ISSUE;
          end else begin
            fail_s = 1'b1;
          end
        end else begin
          adv_s = 1'b1;
        end
      end
`endif
      default: begin
        req_nxt_s   = 1'b0;
        busy_nxt_s  = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase

    case ({fail_s, adv_s})
      2'b10, 2'b11: begin
        err_index_nxt_s = lut_index_r;
        busy_nxt_s      = 1'b0;
        error_nxt_s     = 1'b1;
        req_nxt_s       = 1'b0;
        state_nxt_s     = FAIL;
      end
      2'b01: begin
        retry_nxt_s = '0;
        if (lut_index_r == LAST_INDEX) begin
          busy_nxt_s  = 1'b0;
          done_nxt_s  = 1'b1;
          state_nxt_s = DONE;
        end else begin
          lut_index_nxt_s = lut_index_r + INDEX_W'(1);
          state_nxt_s     = FETCH;
        end
      end
      default: begin
      end
    endcase
  end

  assign lut_index       = lut_index_r;
  assign sccb.xfer_req   = req_r;
  assign sccb.xfer_rd    = rd_r;
  assign sccb.xfer_addr  = addr_r;
  assign sccb.xfer_wdata = data_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign error           = error_r;
  assign id_mismatch     = id_mismatch_r;
  assign err_index       = err_index_r;
`ifdef SCCB_CFG_VERIFY_EN
  assign verify_fail     = verify_fail_r;
`endif

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Directed bench for sccb_config_sequencer: a 5-entry LUT, a logging SCCB
// slave model with programmable NACKs / ID value / readback corruption, and a
// second instance built with ID_STRICT=0 and no power-up wait.
module tb_sccb_config_sequencer;
  localparam int PWR  = 4;
  localparam int SRST = 20;
  localparam int LAT  = 2;

`ifdef SCCB_CFG_VERIFY_EN
  localparam int N_A = 9;
  localparam int N_B = 10;
  localparam int N_C = 8;
  localparam int SRST_POS = 6;
  localparam int NOD_POS  = 6;
  localparam logic [16:0] PASS_A [16] = '{0: 17'h11C00, 1: 17'h11D00, 2: 17'h040D0, 3: 17'h14000,
    4: 17'h040D0, 5: 17'h14000, 6: 17'h01280, 7: 17'h01101, 8: 17'h11100, default: 17'h00000};
  localparam logic [16:0] PASS_B [16] = '{0: 17'h11C00, 1: 17'h11D00, 2: 17'h040D0, 3: 17'h14000,
    4: 17'h01214, 5: 17'h01214, 6: 17'h01214, 7: 17'h11200, 8: 17'h01101, 9: 17'h11100,
    default: 17'h00000};
  localparam logic [16:0] PASS_C [16] = '{0: 17'h11C00, 1: 17'h11D00, 2: 17'h040D0, 3: 17'h14000,
    4: 17'h01214, 5: 17'h01214, 6: 17'h01214, 7: 17'h01214, default: 17'h00000};
`else
  localparam int N_A = 5;
  localparam int N_B = 7;
  localparam int N_C = 7;
  localparam int SRST_POS = 3;
  localparam int NOD_POS  = 5;
  localparam logic [16:0] PASS_A [16] = '{0: 17'h11C00, 1: 17'h11D00, 2: 17'h040D0, 3: 17'h01280,
    4: 17'h01101, default: 17'h00000};
  localparam logic [16:0] PASS_B [16] = '{0: 17'h11C00, 1: 17'h11D00, 2: 17'h040D0, 3: 17'h01214,
    4: 17'h01214, 5: 17'h01214, 6: 17'h01101, default: 17'h00000};
  localparam logic [16:0] PASS_C [16] = '{0: 17'h11C00, 1: 17'h11D00, 2: 17'h040D0, 3: 17'h01214,
    4: 17'h01214, 5: 17'h01214, 6: 17'h01214, default: 17'h00000};
`endif
  localparam logic [16:0] PASS_D [16] = '{0: 17'h11C00, default: 17'h00000};

  logic       clk;
  logic       rst, start, start_lax, lut_sel;
  logic [7:0] lut_index, err_index, lax_index, lax_err_index;
  logic [15:0] lut_data, lax_data;
  logic       busy, done, error, id_mismatch;
  logic       lax_busy, lax_done, lax_error, lax_id_mismatch;
`ifdef SCCB_CFG_VERIFY_EN
  logic       verify_fail, lax_verify_fail;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // slave model controls and transaction log
  logic [7:0] id0_val, nack_addr;
  int         nack_left;
  bit         corrupt_pend;
  logic [7:0] regs [256];
  logic [7:0] lax_regs [256];
  logic       log_rd   [64];
  logic [7:0] log_addr [64];
  logic [7:0] log_wd   [64];
  int         log_req  [64];
  int         log_ack  [64];
  int         n_log;
  int         start_cyc;

  sccb_config_sequencer_if sif ();
  sccb_config_sequencer_if lif ();

  sccb_config_sequencer #(
    .LUT_SIZE(5), .READ_ENTRIES(2), .INDEX_W(8), .POWERUP_CYCLES(PWR),
    .SRST_CYCLES(SRST), .MAX_RETRY(3), .ID_STRICT(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .lut_index(lut_index), .lut_data(lut_data),
    .sccb(sif), .busy(busy), .done(done), .error(error), .id_mismatch(id_mismatch),
    .err_index(err_index)
`ifdef SCCB_CFG_VERIFY_EN
    , .verify_fail(verify_fail)
`endif
  );

  sccb_config_sequencer #(
    .LUT_SIZE(5), .READ_ENTRIES(2), .INDEX_W(8), .POWERUP_CYCLES(0),
    .SRST_CYCLES(SRST), .MAX_RETRY(3), .ID_STRICT(0)
  ) dut_lax (
    .clk(clk), .rst(rst), .start(start_lax), .lut_index(lax_index), .lut_data(lax_data),
    .sccb(lif), .busy(lax_busy), .done(lax_done), .error(lax_error),
    .id_mismatch(lax_id_mismatch), .err_index(lax_err_index)
`ifdef SCCB_CFG_VERIFY_EN
    , .verify_fail(lax_verify_fail)
`endif
  );

  function automatic logic [15:0] lut_entry(input logic [7:0] idx, input logic sel);
    case (idx)
      8'd0:    return 16'h1C7F;
      8'd1:    return 16'h1DA2;
      8'd2:    return 16'h40D0;
      8'd3:    return sel ? 16'h1214 : 16'h1280;
      8'd4:    return 16'h1101;
      default: return 16'h0000;
    endcase
  endfunction

  assign lut_data = lut_entry(lut_index, lut_sel);
  assign lax_data = lut_entry(lax_index, 1'b1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // free-running cycle counter for latency measurements
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag, input logic [16:0] exp_tab [16], input int n_exp);
    logic [16:0] o, e;
    check_eq({tag, "_len"}, 32'(n_log), 32'(n_exp));
    for (int i = 0; i < n_exp; i++) begin
      o = {log_rd[i], log_addr[i], log_rd[i] ? 8'h00 : log_wd[i]};
      e = exp_tab[i][16] ? {exp_tab[i][16:8], 8'h00} : exp_tab[i];
      check_eq($sformatf("%s_txn%0d", tag, i), 32'(o), 32'(e));
    end
  endtask

  task automatic pulse_start(input bit lax);
    @(negedge clk);
    if (lax) start_lax = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_lax = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input bit lax, input int budget);
    bit timed_out;
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!(lax ? lax_busy : busy)) begin
        timed_out = 1'b0;
        break;
      end
    end
    check_eq({tag, "_timeout"}, 32'(timed_out), 32'd0);
  endtask

  // main SCCB slave model: logs each request, answers LAT+1 cycles later
  initial begin : main_slave
    int lat;
    bit pend;
    logic nk;
    logic [7:0] rv;
    pend = 1'b0; lat = 0; nk = 1'b0; rv = 8'h00;
    sif.xfer_ack = 1'b0; sif.xfer_nack = 1'b0; sif.xfer_rdata = 8'h00;
    forever begin
      @(negedge clk);
      sif.xfer_ack = 1'b0;
      sif.xfer_nack = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else if (pend) begin
        if (lat == 0) begin
          check_eq("payload_stable", {14'd0, sif.xfer_req, sif.xfer_rd, sif.xfer_addr, sif.xfer_wdata},
                   {14'd0, 1'b1, log_rd[n_log-1], log_addr[n_log-1], log_wd[n_log-1]});
          sif.xfer_ack = 1'b1;
          sif.xfer_nack = nk;
          sif.xfer_rdata = rv;
          log_ack[n_log-1] = cyc;
          pend = 1'b0;
        end else begin
          lat--;
        end
      end else if (sif.xfer_req && n_log < 64) begin
        log_rd[n_log] = sif.xfer_rd;
        log_addr[n_log] = sif.xfer_addr;
        log_wd[n_log] = sif.xfer_wdata;
        log_req[n_log] = cyc;
        n_log++;
        nk = (nack_left > 0) && (sif.xfer_addr == nack_addr);
        if (nk) nack_left--;
        rv = 8'h00;
        if (sif.xfer_rd) begin
          if (sif.xfer_addr == 8'h1C) rv = id0_val;
          else if (sif.xfer_addr == 8'h1D) rv = 8'hA2;
          else begin
            rv = regs[sif.xfer_addr];
            if (corrupt_pend && sif.xfer_addr == 8'h40) begin
              rv = ~rv;
              corrupt_pend = 1'b0;
            end
          end
        end else if (!nk) begin
          regs[sif.xfer_addr] = sif.xfer_wdata;
        end
        pend = 1'b1;
        lat = LAT;
      end
    end
  end

  // second slave model: always ACKs, ID registers read back as 0x00
  initial begin : lax_slave
    int lat;
    bit pend;
    logic [7:0] rv;
    pend = 1'b0; lat = 0; rv = 8'h00;
    lif.xfer_ack = 1'b0; lif.xfer_nack = 1'b0; lif.xfer_rdata = 8'h00;
    for (int i = 0; i < 256; i++) lax_regs[i] = 8'h00;
    forever begin
      @(negedge clk);
      lif.xfer_ack = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else if (pend) begin
        if (lat == 0) begin
          lif.xfer_ack = 1'b1;
          lif.xfer_rdata = rv;
          pend = 1'b0;
        end else begin
          lat--;
        end
      end else if (lif.xfer_req) begin
        if (lif.xfer_rd) begin
          rv = (lif.xfer_addr == 8'h1C || lif.xfer_addr == 8'h1D) ? 8'h00 : lax_regs[lif.xfer_addr];
        end else begin
          lax_regs[lif.xfer_addr] = lif.xfer_wdata;
          rv = 8'h00;
        end
        pend = 1'b1;
        lat = LAT;
      end
    end
  end

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0; start_lax = 1'b0; lut_sel = 1'b0;
    id0_val = 8'h7F; nack_addr = 8'h00; nack_left = 0; corrupt_pend = 1'b0; n_log = 0;
    for (int i = 0; i < 256; i++) regs[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", {8'd0, busy, done, error, id_mismatch, sif.xfer_req, 3'd0, lut_index, err_index},
             32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // pass A: normal walk with soft reset on entry 3, extra start ignored
    n_log = 0; lut_sel = 1'b0; corrupt_pend = 1'b1;
    start_cyc = cyc;
    pulse_start(1'b0);
    repeat (10) @(negedge clk);
    pulse_start(1'b0);
    wait_idle("pass_a", 1'b0, 3000);
    check_log("pass_a", PASS_A, N_A);
    check_eq("pass_a_status", {28'd0, busy, done, error, id_mismatch}, 32'h4);
    check_eq("pass_a_pwrup_wait", 32'((log_req[0] - start_cyc) >= PWR), 32'd1);
    check_eq("pass_a_srst_gap", 32'((log_req[SRST_POS+1] - log_ack[SRST_POS]) >= SRST), 32'd1);
`ifdef SCCB_CFG_VERIFY_EN
    check_eq("pass_a_verify_fail", 32'(verify_fail), 32'd1);
`endif

    // pass B: fresh pass after DONE, entry 3 = {0x12,0x14} NACKs twice
    n_log = 0; lut_sel = 1'b1; nack_addr = 8'h12; nack_left = 2;
    pulse_start(1'b0);
    wait_idle("pass_b", 1'b0, 3000);
    check_log("pass_b", PASS_B, N_B);
    check_eq("pass_b_status", {28'd0, busy, done, error, id_mismatch}, 32'h4);
    check_eq("pass_b_no_delay", 32'((log_req[NOD_POS+1] - log_ack[NOD_POS]) <= 5), 32'd1);
`ifdef SCCB_CFG_VERIFY_EN
    check_eq("pass_b_verify_fail", 32'(verify_fail), 32'd0);
`endif

    // reset while a transaction to entry 2 is outstanding
    n_log = 0; nack_left = 0;
    pulse_start(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (sif.xfer_req && lut_index == 8'd2) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("rst_reach_wait", 32'(seen), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_async_outputs", {8'd0, busy, done, error, id_mismatch, sif.xfer_req, 3'd0, lut_index, err_index},
             32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("rst_stays_idle", {30'd0, busy, sif.xfer_req}, 32'd0);

    // pass C: entry 3 NACKs four times -> abort at index 3
    n_log = 0; nack_addr = 8'h12; nack_left = 4;
    pulse_start(1'b0);
    wait_idle("pass_c", 1'b0, 3000);
    check_log("pass_c", PASS_C, N_C);
    check_eq("pass_c_status", {28'd0, busy, done, error, id_mismatch}, 32'h2);
    check_eq("pass_c_err_index", 32'(err_index), 32'd3);

    // pass D: wrong ID; strict instance aborts, lax instance completes
    n_log = 0; nack_left = 0; id0_val = 8'h00;
    fork
      pulse_start(1'b0);
      pulse_start(1'b1);
    join
    wait_idle("pass_d", 1'b0, 3000);
    wait_idle("pass_d_lax", 1'b1, 3000);
    check_log("pass_d", PASS_D, 1);
    check_eq("pass_d_status", {28'd0, busy, done, error, id_mismatch}, 32'h3);
    check_eq("pass_d_err_index", 32'(err_index), 32'd0);
    check_eq("pass_d_lax_status", {28'd0, lax_busy, lax_done, lax_error, lax_id_mismatch}, 32'h5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sccb_config_sequencer.md
Name: sccb_config_sequencer

Overview:
- Walks a combinational SCCB register LUT of {reg_addr, reg_data} entries and issues each entry to the SCCB master through a req/ack handshake.
- The first READ_ENTRIES entries are ID reads and are compared with the expected data. All remaining entries are writes.
- Adds soft-reset settle delay, NACK retry and status reporting, so the camera config path no longer needs a hard-coded fixed-length walk.
- Sits between the OV7670 config LUT and the SCCB bit-level master in the camera front end.

Parameters:
- LUT_SIZE, 173: total entries, indices 0..LUT_SIZE-1.
- READ_ENTRIES, 2: leading entries treated as ID-check reads.
- INDEX_W, 8: width of lut_index; must satisfy 2^INDEX_W >= LUT_SIZE.
- POWERUP_CYCLES, 25000: wait after start before the first transaction.
- SRST_CYCLES, 25000: wait after a write to reg 0x12 with data bit7 = 1 (soft reset).
- MAX_RETRY, 3: re-issues of an entry after NACK before failing.
- ID_STRICT, 1: 1 = ID mismatch goes to FAIL; 0 = flag it and continue.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a configuration pass.
- lut_index  out  INDEX_W  entry index presented to the LUT.
- lut_data  in  16  {addr[15:8], data[7:0]}; combinational response to lut_index.
- xfer_req  out  1  transaction request; held until xfer_ack.
- xfer_rd  out  1  1 = read, 0 = write; stable while xfer_req is high.
- xfer_addr  out  8  register address.
- xfer_wdata  out  8  write data.
- xfer_ack  in  1  one-cycle completion pulse from the SCCB master.
- xfer_nack  in  1  valid with xfer_ack; slave did not acknowledge.
- xfer_rdata  in  8  read data, valid with xfer_ack when xfer_rd = 1.
- busy  out  1  pass in progress.
- done  out  1  pass completed successfully; sticky until the next start.
- error  out  1  pass aborted; sticky until the next start.
- id_mismatch  out  1  at least one ID read differed from its expected value.
- err_index  out  INDEX_W  index of the failing entry.

Behaviour:
- Reset values: all outputs 0, state IDLE. Reset mid-transaction deasserts xfer_req immediately; the SCCB master is reset by the same rst.
- States: IDLE, PWRUP, FETCH, ISSUE, WAIT, CHECK, DELAY, DONE, FAIL.
- IDLE/DONE/FAIL + start:
  - clear done, error and id_mismatch;
  - lut_index = 0, retry count = 0, busy = 1;
  - go to PWRUP.
- start while busy is ignored.
- PWRUP: count POWERUP_CYCLES, then go to FETCH. POWERUP_CYCLES = 0 skips straight to FETCH.
- FETCH (1 cycle):
  - register addr/data from lut_data;
  - op = read if lut_index < READ_ENTRIES, else write;
  - go to ISSUE.
- ISSUE: assert xfer_req with addr/rd/wdata from the registered copies, then go to WAIT.
- WAIT:
  - hold xfer_req and the payload stable until xfer_ack;
  - drop xfer_req in the cycle after the ack is sampled;
  - go to CHECK.
- CHECK, NACK:
  - retry count < MAX_RETRY: increment it and return to ISSUE;
  - otherwise: err_index = lut_index, go to FAIL.
- CHECK, read ACK: if xfer_rdata != expected data, set id_mismatch. If ID_STRICT = 1, also set err_index and go to FAIL.
- CHECK, write ACK: if addr == 0x12 and data[7] = 1, go to DELAY (SRST_CYCLES).
- Entry advance, from CHECK or from DELAY after it expires:
  - retry count = 0;
  - if lut_index == LUT_SIZE-1, go to DONE; else increment lut_index and go to FETCH.
- DONE: done = 1, busy = 0.
- FAIL: error = 1, busy = 0.
- Retry counter width is clog2(MAX_RETRY+1). MAX_RETRY = 0 means fail on the first NACK.
- A spurious xfer_ack outside WAIT is ignored.
- LUT_SIZE == READ_ENTRIES yields a read-only pass. The last index must not overflow: no wrap to 0.
- Minimum per-entry cycles = 3 + SCCB latency.

Optional Feature:
- Macro: SCCB_CFG_VERIFY_EN.
- Defined: after each ACKed write (except a soft-reset write to 0x12), issue a read of the same address and compare with the written data.
  - A mismatch counts as a retry: the write is re-issued.
  - When retries are exhausted: err_index = lut_index, go to FAIL.
  - Adds states VREAD and VCHECK.
  - Adds output verify_fail (1 bit, reset 0), set on any mismatch and cleared by start.
- Undefined: no readback, no extra states, verify_fail absent.

Test Plan:
- LUT_SIZE=5, READ_ENTRIES=2, POWERUP_CYCLES=4, model always ACKs and returns 0x7F/0xA2 -> exactly 2 reads then 3 writes in index order, done=1, error=0, busy=0.
- ID read returns 0x00 for entry 0 with ID_STRICT=1 -> id_mismatch=1, error=1, err_index=0, no writes issued. With ID_STRICT=0 -> id_mismatch=1, done=1.
- Entry 3 NACKs twice then ACKs, MAX_RETRY=3 -> 3 issues of entry 3 with identical payload, done=1. NACKs 4 times -> error=1, err_index=3.
- Entry {0x12, 0x80} -> the next xfer_req is delayed by ≥SRST_CYCLES cycles after the ack. Entry {0x12, 0x14} -> no delay.
- rst asserted during WAIT -> all outputs 0 next edge. start pulsed while busy -> ignored. start after DONE -> fresh pass from index 0.
- SCCB_CFG_VERIFY_EN defined, model corrupts the first readback of entry 2 -> write re-issued once, verify_fail=1, done=1.
